fir_coeff_loader: RTL and testbench

Coefficient-update sequencer for the reconfigurable 40-tap FIR filter. Accepts a stream of 16-bit coefficients from a host over a valid/ready handshake. Waits for a sample boundary so no MAC pass is cut mid-way, then raises the filter's coefficient-update flag and writes the taps into the filter's flat 6-bit RAM address space, one write per accepted word. Sits between the host/config interface and the filter's iCoeffUpdateFlag/iCsnRam/iWrnRam/iAddrRam/iWtDtRam inputs.

---
 rtl/fir_coeff_loader_if.sv | 46 ++++
 rtl/fir_coeff_loader.sv | 162 ++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_loader_if.sv
// Host coefficient stream plus filter coefficient-RAM write port for fir_coeff_loader.
// The checksum signals iExpSum/oSumErr exist only when COEFF_CHECKSUM_EN is defined.
interface fir_coeff_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              iStart;
  logic              iEnSample600k;
  logic              iCoeffValid;
  logic [DATA_W-1:0] iCoeffData;
  logic              oCoeffReady;
  logic              oCoeffUpdateFlag;
  logic              oCsnRam;
  logic              oWrnRam;
  logic [ADDR_W-1:0] oAddrRam;
  logic [DATA_W-1:0] oWtDtRam;
  logic              oBusy;
  logic              oDone;
  logic              oTimeout;
`ifdef COEFF_CHECKSUM_EN
  logic [15:0]       iExpSum;
  logic              oSumErr;
`endif

  // Host / configuration side.
  modport master (
`ifdef COEFF_CHECKSUM_EN
    output iExpSum,
    input  oSumErr,
`endif
    output iStart, iEnSample600k, iCoeffValid, iCoeffData,
    input  oCoeffReady, oCoeffUpdateFlag, oCsnRam, oWrnRam, oAddrRam, oWtDtRam,
    input  oBusy, oDone, oTimeout
  );

  // Loader side.
  modport slave (
`ifdef COEFF_CHECKSUM_EN
    input  iExpSum,
    output oSumErr,
`endif
    input  iStart, iEnSample600k, iCoeffValid, iCoeffData,
    output oCoeffReady, oCoeffUpdateFlag, oCsnRam, oWrnRam, oAddrRam, oWtDtRam,
    output oBusy, oDone, oTimeout
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Coefficient-update sequencer for the 40-tap FIR: aligns to a sample strobe, then streams
// host words into the filter RAM. Optional word checksum is enabled by COEFF_CHECKSUM_EN.
module fir_coeff_loader #(
  parameter int NUM_TAPS = 40,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int TIMEOUT  = 255
) (
  input logic               iClk12M,
  input logic               iRsn,
  fir_coeff_loader_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ARM,
    ST_WRITE,
    ST_FLUSH,
    ST_DONE,
    ST_ABORT
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(NUM_TAPS - 1);
  localparam logic [7:0]        STALL_MAX = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tap_cnt_q, tap_cnt_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic              ready_q, ready_d;
  logic              flag_q, flag_d;
  logic              csn_q, csn_d;
  logic              wrn_q, wrn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              accept;

  // ready_q is only ever high in WRITE, so this is the whole handshake.
  assign accept = bus.iCoeffValid & ready_q;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    stall_cnt_d = stall_cnt_q;
    csn_d       = 1'b1;
    wrn_d       = 1'b1;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    case (state_q)
      ST_IDLE: begin
        tap_cnt_d   = '0;
        stall_cnt_d = '0;
        if (bus.iStart) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (bus.iEnSample600k) state_d = ST_ARM;
      end
      ST_ARM: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (accept) begin
          csn_d       = 1'b0;
          wrn_d       = 1'b0;
          addr_d      = tap_cnt_q;
          wdata_d     = bus.iCoeffData;
          tap_cnt_d   = tap_cnt_q + 1'b1;
          stall_cnt_d = '0;
          if (tap_cnt_q == LAST_TAP) state_d = ST_FLUSH;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
          if (stall_cnt_d == STALL_MAX) state_d = ST_ABORT;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the state being entered, so they line up with state_q.
    ready_d   = (state_d == ST_WRITE);
    flag_d    = (state_d == ST_ARM) || (state_d == ST_WRITE) || (state_d == ST_FLUSH);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    timeout_d = (state_d == ST_ABORT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge iClk12M) begin
    if (iRsn) begin
      state_q     <= ST_IDLE;
      tap_cnt_q   <= '0;
      stall_cnt_q <= '0;
      ready_q     <= 1'b0;
      flag_q      <= 1'b0;
      csn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      ready_q     <= ready_d;
      flag_q      <= flag_d;
      csn_q       <= csn_d;
      wrn_q       <= wrn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.oCoeffReady      = ready_q;
  assign bus.oCoeffUpdateFlag = flag_q;
  assign bus.oCsnRam          = csn_q;
  assign bus.oWrnRam          = wrn_q;
  assign bus.oAddrRam         = addr_q;
  assign bus.oWtDtRam         = wdata_q;
  assign bus.oBusy            = busy_q;
  assign bus.oDone            = done_q;
  assign bus.oTimeout         = timeout_q;

`ifdef COEFF_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic        sum_err_q, sum_err_d;

  // Sum restarts in ARM; the verdict is latched on entry to DONE and kept until the next load request.
  always_comb begin
    sum_d     = sum_q;
    sum_err_d = sum_err_q;
    if (state_q == ST_ARM) sum_d = '0;
    else if (accept)       sum_d = sum_q + 16'(bus.iCoeffData);
    if (state_q == ST_IDLE && bus.iStart) sum_err_d = 1'b0;
    if (state_d == ST_DONE)               sum_err_d = (sum_q != bus.iExpSum);
  end

  always_ff @(posedge iClk12M) begin
    if (iRsn) begin
      sum_q     <= '0;
      sum_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      sum_err_q <= sum_err_d;
    end
  end

  assign bus.oSumErr = sum_err_q;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader: each load is planned up front as a per-cycle expected
// trace derived from the host valid pattern and strobe timing, then compared cycle by cycle.
module tb_fir_coeff_loader;
  localparam int NUM_TAPS  = 40;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 16;
  localparam int TIMEOUT   = 8;
  localparam int PERIOD    = 20;
  localparam int STROBE_PH = 7;
  localparam int MAXW      = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fir_coeff_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fir_coeff_loader #(
    .NUM_TAPS(NUM_TAPS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .iClk12M(clk),
    .iRsn   (rst),
    .bus    (bus)
  );

  // Values that persist between loads (RAM port holds its last address/data).
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_data = '0;
  logic              last_serr = 1'b0;

  // Per-cycle plan of one load, indexed by cycle offset from the iStart cycle.
  bit                e_busy[MAXW], e_flag[MAXW], e_ready[MAXW], e_wr[MAXW];
  bit                e_done[MAXW], e_to[MAXW], e_serr[MAXW];
  logic [ADDR_W-1:0] e_addr[MAXW];
  logic [DATA_W-1:0] e_data[MAXW];
  bit                v_in[MAXW], st_in[MAXW];
  logic [DATA_W-1:0] d_in[MAXW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.iEnSample600k = (cyc % PERIOD == STROBE_PH);
  endtask

  function automatic int delay_to(input int ph);
    int d;
    d = 1;
    while ((cyc + d) % PERIOD != ph) d++;
    return d;
  endfunction

  // mode: 0 valid always, 1 valid toggles, 2 five words then stall, 3 random 70%, 4 random 35%.
  // rst_after: reset during the strobe of that write (0 = none). exp_off: added to true sum for iExpSum.
  task automatic run_load(input int delay, input int mode, input int rst_after, input int exp_off);
    int                t0, ts, w0, n, stall, endc, rc, len;
    bit                v, in_rst;
    logic [DATA_W-1:0] sum, exp_sum, cur_data;
    logic [ADDR_W-1:0] cur_addr;
    logic              serr;

    t0 = cyc + delay;
    ts = t0 + 1;
    while (ts % PERIOD != STROBE_PH) ts++;
    w0 = ts + 2;

    for (int k = 0; k < MAXW; k++) begin
      e_busy[k] = 0; e_flag[k] = 0; e_ready[k] = 0; e_wr[k] = 0;
      e_done[k] = 0; e_to[k] = 0; e_serr[k] = 0;
      e_addr[k] = '0; e_data[k] = '0;
      v_in[k] = ($urandom_range(0, 1) == 1);
      d_in[k] = DATA_W'($urandom);
      st_in[k] = 0;
    end
    st_in[0] = 1;

    n = 0; stall = 0; sum = '0; endc = -1; rc = -1;
    for (int c = w0; endc < 0; c++) begin
      case (mode)
        0:       v = 1;
        1:       v = ((c - w0) % 2 == 0);
        2:       v = (c - w0 < 5);
        3:       v = ($urandom_range(0, 9) < 7);
        default: v = ($urandom_range(0, 19) < 7);
      endcase
      v_in[c-t0]    = v;
      e_ready[c-t0] = 1;
      if (v) begin
        if (mode < 3) d_in[c-t0] = DATA_W'(n + 1);
        e_wr[c+1-t0]   = 1;
        e_addr[c+1-t0] = ADDR_W'(n);
        e_data[c+1-t0] = d_in[c-t0];
        sum   += d_in[c-t0];
        n++;
        stall = 0;
        if (n == rst_after) rc = c + 1;
        if (n == NUM_TAPS)  endc = c + 2;
      end else begin
        stall++;
        if (stall == TIMEOUT) endc = c + 1;
      end
    end
    exp_sum = sum + DATA_W'(exp_off);

    for (int c = t0 + 1; c <= endc; c++) begin
      e_busy[c-t0] = 1;
      st_in[c-t0]  = ($urandom_range(0, 3) == 0);
    end
    for (int c = ts + 1; c < endc; c++) e_flag[c-t0] = 1;
    if (n == NUM_TAPS) e_done[endc-t0] = 1;
    else               e_to[endc-t0]   = 1;

    len = (rc >= 0) ? rc + 2 - t0 : endc + 2 - t0;
    cur_addr = last_addr; cur_data = last_data; serr = last_serr;
    for (int k = 0; k < len; k++) begin
      in_rst = (rc >= 0) && (t0 + k > rc);
      if (k == 1) serr = 0;
      if (t0 + k == endc && n == NUM_TAPS) serr = (sum != exp_sum);
      if (in_rst) begin
        e_busy[k] = 0; e_flag[k] = 0; e_ready[k] = 0; e_wr[k] = 0;
        e_done[k] = 0; e_to[k] = 0; st_in[k] = 0;
        cur_addr = '0; cur_data = '0; serr = 0;
      end else if (e_wr[k]) begin
        cur_addr = e_addr[k];
        cur_data = e_data[k];
      end
      e_addr[k] = cur_addr;
      e_data[k] = cur_data;
      e_serr[k] = serr;
    end

    bus.iStart = 1'b0;
`ifdef COEFF_CHECKSUM_EN
    bus.iExpSum = exp_sum;
`endif
    while (cyc < t0) tick();

    for (int k = 0; k < len; k++) begin
      bus.iStart      = st_in[k];
      bus.iCoeffValid = v_in[k];
      bus.iCoeffData  = d_in[k];
      rst             = (rc >= 0) && (t0 + k == rc);
      check("busy",  32'(bus.oBusy),            32'(e_busy[k]));
      check("flag",  32'(bus.oCoeffUpdateFlag), 32'(e_flag[k]));
      check("ready", 32'(bus.oCoeffReady),      32'(e_ready[k]));
      check("csn",   32'(bus.oCsnRam),          32'(!e_wr[k]));
      check("wrn",   32'(bus.oWrnRam),          32'(!e_wr[k]));
      check("addr",  32'(bus.oAddrRam),         32'(e_addr[k]));
      check("wdata", 32'(bus.oWtDtRam),         32'(e_data[k]));
      check("done",  32'(bus.oDone),            32'(e_done[k]));
      check("tmo",   32'(bus.oTimeout),         32'(e_to[k]));
`ifdef COEFF_CHECKSUM_EN
      check("sumerr", 32'(bus.oSumErr),         32'(e_serr[k]));
`endif
      tick();
    end
    rst             = 1'b0;
    bus.iStart      = 1'b0;
    bus.iCoeffValid = 1'b0;
    last_addr = e_addr[len-1];
    last_data = e_data[len-1];
    last_serr = e_serr[len-1];
  endtask

  initial begin
    bus.iStart        = 1'b0;
    bus.iCoeffValid   = 1'b0;
    bus.iCoeffData    = '0;
    bus.iEnSample600k = (STROBE_PH == 0);
`ifdef COEFF_CHECKSUM_EN
    bus.iExpSum       = '0;
`endif
    rst = 1'b1;
    tick();
    tick();
    check("rst_csn",   32'(bus.oCsnRam),          32'd1);
    check("rst_wrn",   32'(bus.oWrnRam),          32'd1);
    check("rst_addr",  32'(bus.oAddrRam),         32'd0);
    check("rst_wdata", 32'(bus.oWtDtRam),         32'd0);
    check("rst_flag",  32'(bus.oCoeffUpdateFlag), 32'd0);
    check("rst_ready", 32'(bus.oCoeffReady),      32'd0);
    check("rst_busy",  32'(bus.oBusy),            32'd0);
    check("rst_done",  32'(bus.oDone),            32'd0);
    check("rst_tmo",   32'(bus.oTimeout),         32'd0);
`ifdef COEFF_CHECKSUM_EN
    check("rst_sumerr", 32'(bus.oSumErr),         32'd0);
`endif
    rst = 1'b0;
    tick();

    run_load(delay_to((STROBE_PH + 5) % PERIOD), 0, 0, 0);   // nominal, sum matches
    run_load(delay_to((STROBE_PH + 3) % PERIOD), 0, 0, 1);   // start 3 after strobe, sum off by one
    run_load(delay_to(STROBE_PH),                1, 0, 0);   // start coincides with strobe, backpressure
    run_load(delay_to((STROBE_PH + 9) % PERIOD), 2, 0, 0);   // timeout after five words
    run_load(delay_to((STROBE_PH + 1) % PERIOD), 0, 20, 0);  // reset after 20 writes
    run_load(delay_to((STROBE_PH + 2) % PERIOD), 0, 0, 0);   // restart from address 0
    for (int i = 0; i < 10; i++)
      run_load(delay_to($urandom_range(0, PERIOD - 1)), 3 + (i % 2), 0, $urandom_range(0, 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
